// File: rtl/bpu_resolve_if.sv
// Prediction push and execute resolution bundle between
// the fetch/BPU stage and the branch resolve queue.
interface bpu_resolve_if #(
  parameter int AW = 8
) ();
  logic          pred_valid_i;
  logic          pred_ready_o;
  logic          pred_taken_i;
  logic [AW-1:0] pred_pc_i;
  logic [AW-1:0] pred_target_i;
  logic          res_valid_i;
  logic          res_taken_i;
  logic [AW-1:0] res_target_i;

  modport slave (
    input  pred_valid_i, pred_taken_i,
    input  pred_pc_i, pred_target_i,
    input  res_valid_i, res_taken_i,
    input  res_target_i,
    output pred_ready_o
  );

  modport master (
    output pred_valid_i, pred_taken_i,
    output pred_pc_i, pred_target_i,
    output res_valid_i, res_taken_i,
    output res_target_i,
    input  pred_ready_o
  );
endinterface

// File: rtl/bpu_resolve_queue.sv
// In-order queue of branch predictions; checks each against
// execute's outcome, updates the BPU and flushes on mispredict.
module bpu_resolve_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  bpu_resolve_if.slave              bus,
  output logic                      upd_valid_o,
  output logic                      conditional_jump_o,
  output logic                      shouldnt_jump_o,
  output logic [ADDR_WIDTH-1:0]     upd_pc_o,
  output logic                      flush_o,
  output logic [ADDR_WIDTH-1:0]     redirect_pc_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [CNT_WIDTH-1:0]      mispredict_cnt_o,
  output logic                      underflow_o
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic                  taken;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
  } entry_t;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state_q, state_d;
  entry_t mem_q [DEPTH];
  entry_t head, wentry;

  logic [PW:0] wr_q, wr_d, rd_q, rd_d, cnt;
  logic run, full, ready, pop, mis, push;

  logic                  upd_v_q, upd_v_d;
  logic                  cj_q, cj_d;
  logic                  sj_q, sj_d;
  logic                  fl_q, fl_d;
  logic                  uf_q, uf_d;
  logic [ADDR_WIDTH-1:0] upc_q, upc_d;
  logic [ADDR_WIDTH-1:0] rpc_q, rpc_d;
  logic [CNT_WIDTH-1:0]  mc_q, mc_d;

  assign cnt   = wr_q - rd_q;
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head  = mem_q[rd_q[PW-1:0]];
  assign run   = (state_q == RUN);
  assign ready = run && !full;
  assign pop   = run && bus.res_valid_i && (cnt != '0);
  assign mis   = pop &&
                 ((head.taken != bus.res_taken_i) ||
                  (bus.res_taken_i &&
                   (head.target != bus.res_target_i)));
  // A mispredict squashes the same-cycle push along with the queue
  assign push  = bus.pred_valid_i && ready && !mis;

  assign wentry = '{taken:  bus.pred_taken_i,
                    pc:     bus.pred_pc_i,
                    target: bus.pred_target_i};

  always_comb begin
    state_d = RUN;
    wr_d    = wr_q;
    rd_d    = rd_q;
    upd_v_d = pop;
    cj_d    = pop && bus.res_taken_i;
    sj_d    = pop && head.taken && !bus.res_taken_i;
    fl_d    = mis;
    upc_d   = upc_q;
    rpc_d   = rpc_q;
    mc_d    = mc_q;
    uf_d    = uf_q;
    unique case (1'b1)
      !run: state_d = RUN;
      mis: begin
        state_d = FLUSH;
        rd_d    = wr_q;
      end
      default: begin
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
      end
    endcase
    if (pop) upc_d = head.pc;
    if (mis) begin
      rpc_d = bus.res_taken_i ? bus.res_target_i
                              : head.pc + ADDR_WIDTH'(1);
      if (~&mc_q) mc_d = mc_q + 1'b1;
    end
    if (run && bus.res_valid_i && (cnt == '0)) uf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      upd_v_q <= 1'b0;
      cj_q    <= 1'b0;
      sj_q    <= 1'b0;
      fl_q    <= 1'b0;
      upc_q   <= '0;
      rpc_q   <= '0;
      mc_q    <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      upd_v_q <= upd_v_d;
      cj_q    <= cj_d;
      sj_q    <= sj_d;
      fl_q    <= fl_d;
      upc_q   <= upc_d;
      rpc_q   <= rpc_d;
      mc_q    <= mc_d;
      uf_q    <= uf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_q[PW-1:0]] <= wentry;
  end

  assign bus.pred_ready_o    = ready;
  assign upd_valid_o         = upd_v_q;
  assign conditional_jump_o  = cj_q;
  assign shouldnt_jump_o     = sj_q;
  assign upd_pc_o            = upc_q;
  assign flush_o             = fl_q;
  assign redirect_pc_o       = rpc_q;
  assign count_o             = cnt;
  assign mispredict_cnt_o    = mc_q;
  assign underflow_o         = uf_q;
endmodule

// File: tb/tb_bpu_resolve_queue.sv
// Directed bench for bpu_resolve_queue: expected BPU updates
// go to a scoreboard, a negedge monitor pops and compares.
module tb_bpu_resolve_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpu_resolve_if #(.AW(8)) bus ();

  logic       upd_valid, cj, sj, flush, uf;
  logic [7:0] upd_pc, redir;
  logic [2:0] count;
  logic [15:0] mcnt;

  bpu_resolve_queue #(
    .DEPTH(4), .ADDR_WIDTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .upd_valid_o(upd_valid),
    .conditional_jump_o(cj),
    .shouldnt_jump_o(sj),
    .upd_pc_o(upd_pc),
    .flush_o(flush),
    .redirect_pc_o(redir),
    .count_o(count),
    .mispredict_cnt_o(mcnt),
    .underflow_o(uf)
  );

  typedef struct packed {
    logic       cj;
    logic       sj;
    logic [7:0] pc;
    logic       fl;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (upd_valid || flush) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_update got=v%0b/f%0b exp=none",
                 upd_valid, flush);
      end else begin
        e = sb.pop_front();
        chk("upd_valid", 32'(upd_valid), 32'd1);
        chk("cond_jump", 32'(cj), 32'(e.cj));
        chk("shouldnt_jump", 32'(sj), 32'(e.sj));
        chk("upd_pc", 32'(upd_pc), 32'(e.pc));
        chk("flush", 32'(flush), 32'(e.fl));
        if (e.fl) chk("redirect_pc", 32'(redir), 32'(e.rd));
      end
    end
  end

  task automatic idle_inputs();
    bus.pred_valid_i  = 1'b0;
    bus.pred_taken_i  = 1'b0;
    bus.pred_pc_i     = 8'h00;
    bus.pred_target_i = 8'h00;
    bus.res_valid_i   = 1'b0;
    bus.res_taken_i   = 1'b0;
    bus.res_target_i  = 8'h00;
  endtask

  task automatic cyc(input logic pv, input logic pt,
                     input logic [7:0] ppc, input logic [7:0] ptg,
                     input logic rv, input logic rt,
                     input logic [7:0] rtg);
    bus.pred_valid_i  = pv;
    bus.pred_taken_i  = pt;
    bus.pred_pc_i     = ppc;
    bus.pred_target_i = ptg;
    bus.res_valid_i   = rv;
    bus.res_taken_i   = rt;
    bus.res_target_i  = rtg;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic push(input logic pt, input logic [7:0] pc,
                      input logic [7:0] tg);
    cyc(1'b1, pt, pc, tg, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic resolve(input logic rt, input logic [7:0] rtg);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, rt, rtg);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic expect_upd(input logic c, input logic s,
                            input logic [7:0] pc,
                            input logic f, input logic [7:0] r);
    sb.push_back('{cj: c, sj: s, pc: pc, fl: f, rd: r});
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(bus.pred_ready_o), 32'd1);
    chk("rst_upd", 32'(upd_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_mcnt", 32'(mcnt), 32'd0);
    chk("rst_uf", 32'(uf), 32'd0);

    // fill to capacity, refuse a fifth push, then drain
    for (int i = 1; i <= 4; i++) push(1'b0, 8'(i), 8'h00);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(bus.pred_ready_o), 32'd0);
    push(1'b0, 8'h05, 8'h00);
    chk("refused_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      expect_upd(1'b0, 1'b0, 8'(i), 1'b0, 8'h00);
      resolve(1'b0, 8'h00);
    end
    chk("drain_count", 32'(count), 32'd0);

    // correct taken prediction
    push(1'b1, 8'h10, 8'h40);
    expect_upd(1'b1, 1'b0, 8'h10, 1'b0, 8'h00);
    resolve(1'b1, 8'h40);
    chk("t2_count", 32'(count), 32'd0);

    // predicted taken, actually not taken
    push(1'b1, 8'h10, 8'h40);
    push(1'b0, 8'h20, 8'h00);
    push(1'b0, 8'h30, 8'h00);
    expect_upd(1'b0, 1'b1, 8'h10, 1'b1, 8'h11);
    resolve(1'b0, 8'h00);
    chk("t3_count", 32'(count), 32'd0);
    chk("t3_mcnt", 32'(mcnt), 32'd1);
    chk("t3_ready_flush", 32'(bus.pred_ready_o), 32'd0);
    // inputs during the flush cycle are ignored
    cyc(1'b1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("t3_ignored_count", 32'(count), 32'd0);
    chk("t3_ready_back", 32'(bus.pred_ready_o), 32'd1);
    chk("t3_no_uf", 32'(uf), 32'd0);

    // not-taken correct, then target redirect, then pc+1 wrap
    push(1'b0, 8'hFF, 8'h00);
    expect_upd(1'b0, 1'b0, 8'hFF, 1'b0, 8'h00);
    resolve(1'b0, 8'h00);
    push(1'b0, 8'hFF, 8'h00);
    expect_upd(1'b1, 1'b0, 8'hFF, 1'b1, 8'h05);
    resolve(1'b1, 8'h05);
    chk("t4_mcnt_a", 32'(mcnt), 32'd2);
    idle();
    push(1'b1, 8'hFF, 8'h00);
    expect_upd(1'b0, 1'b1, 8'hFF, 1'b1, 8'h00);
    resolve(1'b0, 8'h00);
    chk("t4_mcnt_b", 32'(mcnt), 32'd3);
    idle();

    // simultaneous push and correct pop
    push(1'b0, 8'h60, 8'h00);
    push(1'b0, 8'h61, 8'h00);
    expect_upd(1'b0, 1'b0, 8'h60, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h62, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("t5_count_same", 32'(count), 32'd2);
    expect_upd(1'b0, 1'b0, 8'h61, 1'b0, 8'h00);
    resolve(1'b0, 8'h00);
    expect_upd(1'b0, 1'b0, 8'h62, 1'b0, 8'h00);
    resolve(1'b0, 8'h00);
    chk("t5_count_empty", 32'(count), 32'd0);

    // simultaneous push and mispredicting pop
    push(1'b0, 8'h70, 8'h00);
    push(1'b0, 8'h71, 8'h00);
    expect_upd(1'b1, 1'b0, 8'h70, 1'b1, 8'h99);
    cyc(1'b1, 1'b0, 8'h72, 8'h00, 1'b1, 1'b1, 8'h99);
    chk("t5_mis_count", 32'(count), 32'd0);
    chk("t5_mcnt", 32'(mcnt), 32'd4);
    idle();
    chk("t5_lost_count", 32'(count), 32'd0);

    // empty resolution sets sticky underflow
    resolve(1'b0, 8'h00);
    chk("t6_uf", 32'(uf), 32'd1);
    idle();
    idle();
    chk("t6_uf_sticky", 32'(uf), 32'd1);

    // reset beats a same-cycle push and pop
    push(1'b0, 8'h80, 8'h00);
    push(1'b0, 8'h81, 8'h00);
    push(1'b0, 8'h82, 8'h00);
    chk("t6_pre_count", 32'(count), 32'd3);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h83, 8'h00, 1'b1, 1'b0, 8'h00);
    rst = 1'b0;
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_ready", 32'(bus.pred_ready_o), 32'd1);
    chk("t6_rst_uf", 32'(uf), 32'd0);
    chk("t6_rst_mcnt", 32'(mcnt), 32'd0);
    chk("t6_rst_upd", 32'(upd_valid), 32'd0);
    chk("t6_rst_flush", 32'(flush), 32'd0);

    repeat (3) idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
